// File: rtl/uart_rx_deserializer_if.sv
// ----------------------------------------------------------------------------
// uart_rx_deserializer_if
// Bundles the serial input, frame configuration and received-byte outputs of
// the UART receive frame engine.
//   RX_IN      serial line, idle high, synchronous to the receive clock
//   PAR_EN     1 = frame carries a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   Prescale   oversampling ratio (8, 16 or 32)
//   P_DATA     last correctly received data word
//   data_valid one-cycle strobe, P_DATA updated, frame error-free
//   par_err    one-cycle strobe, parity mismatch
//   stp_err    one-cycle strobe, stop bit sampled low
// master: line/config driver side; slave: the deserializer.
// ----------------------------------------------------------------------------
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      data_valid;
    logic                      par_err;
    logic                      stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// uart_rx_deserializer
// UART receive frame engine. Oversamples RX_IN at the latched prescale,
// majority-votes three samples around each bit centre, checks start, parity
// and stop bits and reassembles the LSB-first data word.
//   CLK  receive oversampling clock (rising edge)
//   RST  synchronous, active-high reset
//   bus  uart_rx_deserializer_if.slave: RX_IN, PAR_EN, PAR_TYP, Prescale in;
//        P_DATA, data_valid, par_err, stp_err out (all registered)
// ----------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_rx_deserializer_if.slave   bus
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] P8       = PRESCALE_WIDTH'(8);
    localparam logic [PRESCALE_WIDTH-1:0] P16      = PRESCALE_WIDTH'(16);
    localparam logic [PRESCALE_WIDTH-1:0] P32      = PRESCALE_WIDTH'(32);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state_q;
    state_t                    state_d;

    logic [PRESCALE_WIDTH-1:0] presc_sel;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] smp0_edge;
    logic [PRESCALE_WIDTH-1:0] smp1_edge;
    logic [PRESCALE_WIDTH-1:0] vote_edge;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic                      at_vote;
    logic                      at_last;
    logic                      smp0;
    logic                      smp1;
    logic                      vote;
    logic                      start_det;

    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      par_flag;
    logic                      stp_flag;
    logic [DATA_WIDTH-1:0]     shift_reg;

    logic [DATA_WIDTH-1:0]     p_data_q;
    logic                      data_valid_q;
    logic                      par_err_q;
    logic                      stp_err_q;

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

    // Unsupported ratios fall back to 8x oversampling.
    always_comb begin
        presc_sel = P8;
        if (bus.Prescale == P16 || bus.Prescale == P32) begin
            presc_sel = bus.Prescale;
        end
    end

    // Sample points straddle the bit centre; the vote resolves on the third.
    always_comb begin
        half      = presc_q >> 1;
        smp0_edge = half - ONE;
        smp1_edge = half;
        vote_edge = half + ONE;
        last_edge = presc_q - ONE;
        at_vote   = (edge_cnt == vote_edge);
        at_last   = (edge_cnt == last_edge);
        vote      = (smp0 & smp1) | (smp0 & bus.RX_IN) | (smp1 & bus.RX_IN);
        start_det = (state_q == IDLE) && !bus.RX_IN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_d = START;
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_d = IDLE;
                end else if (at_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_last && bit_cnt == LAST_BIT) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q      <= '0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            smp0         <= 1'b0;
            smp1         <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_flag     <= 1'b0;
            stp_flag     <= 1'b0;
            shift_reg    <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            // The detection cycle counts as edge 0 of the start bit.
            if (state_q == IDLE) begin
                edge_cnt <= start_det ? ONE : '0;
            end else if (at_last || state_d == IDLE) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end

            if (start_det) begin
                presc_q   <= presc_sel;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                par_flag  <= 1'b0;
                stp_flag  <= 1'b0;
                bit_cnt   <= '0;
            end

            if (state_q != IDLE) begin
                if (edge_cnt == smp0_edge) begin
                    smp0 <= bus.RX_IN;
                end
                if (edge_cnt == smp1_edge) begin
                    smp1 <= bus.RX_IN;
                end
            end

            if (state_q == DATA) begin
                if (at_vote) begin
                    shift_reg[bit_cnt] <= vote;
                end
                if (at_last && bit_cnt != LAST_BIT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (state_q == PARITY && at_vote) begin
                if (vote != (^shift_reg ^ par_typ_q)) begin
                    par_flag <= 1'b1;
                end
            end

            if (state_q == STOP) begin
                if (at_vote && !vote) begin
                    stp_flag <= 1'b1;
                end
                // Flags are final by the last edge; P_DATA only moves on a clean frame.
                if (at_last) begin
                    if (!par_flag && !stp_flag) begin
                        data_valid_q <= 1'b1;
                        p_data_q     <= shift_reg;
                    end else begin
                        par_err_q <= par_flag;
                        stp_err_q <= stp_flag;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Directed bench for uart_rx_deserializer: a table of single frames with
// hand-computed outcomes, plus sequences for glitch rejection, back-to-back
// frames with disturbed sample windows, line break and mid-frame reset.
// Cycle k of a frame is driven on the falling edge before rising edge k;
// outputs seen on that falling edge are the "cycle k" values.
// ----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int DW = 8;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    uart_rx_deserializer_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

    uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pd;
    } strobe_t;

    strobe_t log_q[$];

    always @(negedge clk) begin
        if (!rst && (bus.data_valid || bus.par_err || bus.stp_err)) begin
            strobe_t s;
            s.cyc = cyc;
            s.dv  = bus.data_valid;
            s.pe  = bus.par_err;
            s.se  = bus.stp_err;
            s.pd  = bus.P_DATA;
            log_q.push_back(s);
        end
    end

    typedef struct {
        int         presc;
        int         p_eff;
        bit         pe;
        bit         pt;
        logic [7:0] data;
        bit         pbit;
        bit         stop;
        bit         flip;
        bit         exp_dv;
        bit         exp_perr;
        bit         exp_serr;
        logic [7:0] exp_pd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.RX_IN = 1'b1;
        end
    endtask

    // Drives up to 'limit' cycles of one frame starting at cycle 0.
    task automatic drive_frame(input int presc, input int p_eff, input bit pe, input bit pt,
                               input logic [7:0] data, input bit pbit, input bit stop,
                               input bit flip, input int limit, output int t0);
        int          n;
        logic [10:0] fb;
        logic        b;
        n      = 10 + int'(pe);
        fb     = '1;
        fb[0]  = 1'b0;
        fb[8:1] = data;
        if (pe) begin
            fb[9]  = pbit;
            fb[10] = stop;
        end else begin
            fb[9] = stop;
        end
        t0 = 0;
        for (int k = 0; k < n * p_eff && k < limit; k++) begin
            @(negedge clk);
            if (k == 0) begin
                t0           = cyc;
                bus.Prescale = PW'(presc);
                bus.PAR_EN   = pe;
                bus.PAR_TYP  = pt;
            end
            b = fb[k / p_eff];
            if (flip && (k % p_eff) == p_eff / 2 - 1) b = ~b;
            bus.RX_IN = b;
        end
    endtask

    task automatic expect_strobe(input string name, input int exp_cyc, input bit dv,
                                 input bit pe, input bit se, input logic [7:0] pd);
        strobe_t s;
        if (log_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no strobe seen, expected one at cycle %0d", name, exp_cyc);
        end else begin
            s = log_q.pop_front();
            check({name, ".cycle"}, s.cyc, exp_cyc);
            check({name, ".data_valid"}, 32'(s.dv), 32'(dv));
            check({name, ".par_err"}, 32'(s.pe), 32'(pe));
            check({name, ".stp_err"}, 32'(s.se), 32'(se));
            if (dv) check({name, ".P_DATA"}, 32'(s.pd), 32'(pd));
        end
    endtask

    task automatic expect_quiet(input string name);
        #1;
        check({name, ".extra_strobes"}, log_q.size(), 0);
        log_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got cyc=%0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int t1;
        int n;

        bus.RX_IN    = 1'b1;
        bus.Prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;

        //                presc p_eff pe pt data   pbit stop flip dv perr serr exp_pd
        vecs[0] = '{8,  8,  0, 0, 8'hA5, 0, 1, 0, 1, 0, 0, 8'hA5};
        vecs[1] = '{16, 16, 1, 0, 8'h3C, 0, 1, 0, 1, 0, 0, 8'h3C};
        vecs[2] = '{16, 16, 1, 1, 8'h3C, 0, 1, 0, 0, 1, 0, 8'h3C};
        vecs[3] = '{32, 32, 0, 0, 8'h81, 0, 0, 0, 0, 0, 1, 8'h3C};
        vecs[4] = '{12, 8,  0, 0, 8'h5A, 0, 1, 0, 1, 0, 0, 8'h5A};
        vecs[5] = '{8,  8,  1, 1, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00};
        vecs[6] = '{8,  8,  1, 0, 8'hFF, 1, 0, 0, 0, 1, 1, 8'h00};
        vecs[7] = '{16, 16, 0, 0, 8'hC3, 0, 1, 1, 1, 0, 0, 8'hC3};

        // Reset and idle line.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.P_DATA", 32'(bus.P_DATA), 32'h0);
        check("reset.data_valid", 32'(bus.data_valid), 32'h0);
        check("reset.par_err", 32'(bus.par_err), 32'h0);
        check("reset.stp_err", 32'(bus.stp_err), 32'h0);
        idle(100);
        check("idle.P_DATA", 32'(bus.P_DATA), 32'h0);
        expect_quiet("idle");

        // Single frames.
        for (int i = 0; i < 8; i++) begin
            idle(4);
            log_q.delete();
            drive_frame(vecs[i].presc, vecs[i].p_eff, vecs[i].pe, vecs[i].pt, vecs[i].data,
                        vecs[i].pbit, vecs[i].stop, vecs[i].flip, 100000, t0);
            idle(3);
            #1;
            n = 10 + int'(vecs[i].pe);
            expect_strobe($sformatf("vec%0d", i), t0 + n * vecs[i].p_eff, vecs[i].exp_dv,
                          vecs[i].exp_perr, vecs[i].exp_serr, vecs[i].exp_pd);
            check($sformatf("vec%0d.P_DATA_hold", i), 32'(bus.P_DATA), 32'(vecs[i].exp_pd));
            expect_quiet($sformatf("vec%0d", i));
        end

        // Three-cycle glitch is rejected, then a clean frame still decodes.
        idle(4);
        log_q.delete();
        bus.Prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus.RX_IN = 1'b0;
        end
        idle(40);
        expect_quiet("glitch");
        drive_frame(8, 8, 0, 0, 8'h66, 0, 1, 0, 100000, t0);
        idle(3);
        #1;
        expect_strobe("after_glitch", t0 + 80, 1, 0, 0, 8'h66);
        expect_quiet("after_glitch");

        // Back-to-back frames, one inverted cycle in every sample window.
        idle(4);
        log_q.delete();
        drive_frame(8, 8, 0, 0, 8'h55, 0, 1, 1, 100000, t0);
        drive_frame(8, 8, 0, 0, 8'hF0, 0, 1, 1, 100000, t1);
        idle(3);
        #1;
        check("b2b.gap", t1 - t0, 80);
        expect_strobe("b2b.first", t0 + 80, 1, 0, 0, 8'h55);
        expect_strobe("b2b.second", t0 + 160, 1, 0, 0, 8'hF0);
        expect_quiet("b2b");

        // Line break: all-zero frame with low stop, next start detected at once.
        idle(4);
        log_q.delete();
        drive_frame(8, 8, 0, 0, 8'h00, 0, 0, 0, 100000, t0);
        drive_frame(8, 8, 0, 0, 8'h0F, 0, 1, 0, 100000, t1);
        idle(3);
        #1;
        expect_strobe("break.stp", t0 + 80, 0, 0, 1, 8'h00);
        expect_strobe("break.next", t0 + 160, 1, 0, 0, 8'h0F);
        expect_quiet("break");

        // Reset during data bit 4 aborts the frame.
        idle(4);
        log_q.delete();
        drive_frame(8, 8, 0, 0, 8'h99, 0, 1, 0, 44, t0);
        @(negedge clk);
        rst = 1'b1;
        bus.RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(20);
        check("midreset.P_DATA", 32'(bus.P_DATA), 32'h0);
        expect_quiet("midreset");
        drive_frame(8, 8, 0, 0, 8'h3E, 0, 1, 0, 100000, t0);
        idle(3);
        #1;
        expect_strobe("after_reset", t0 + 80, 1, 0, 0, 8'h3E);
        expect_quiet("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive-side frame engine, the counterpart to the Tx serializer. It oversamples RX_IN at a configurable prescale, majority-votes each bit, checks start, parity and stop bits, and reassembles the LSB-first data byte onto P_DATA. It sits between the Rx synchronizer (RX_IN is already synchronous to CLK) and the Rx data-sync / register-file path, and reports completion with a one-cycle data_valid strobe.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB first
PRESCALE_WIDTH, 6, width of the Prescale port and the internal edge counter

Ports:
CLK  in  1  receive oversampling clock; one clock, all logic on its rising edge
RST  in  1  reset is synchronous and active-high
RX_IN  in  1  serial line, idle high, already synchronized to CLK
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
Prescale  in  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
P_DATA  out  DATA_WIDTH  last correctly received byte
data_valid  out  1  one-cycle strobe, P_DATA updated and frame error-free
par_err  out  1  one-cycle strobe, parity mismatch in the completed frame
stp_err  out  1  one-cycle strobe, stop bit sampled 0

Behaviour:
- Reset (RST=1 at a rising edge): FSM to IDLE, all counters to 0, P_DATA=0, data_valid=0, par_err=0, stp_err=0. Reset mid-frame aborts the frame; no strobes are produced for it.
- All outputs are registered.
- Prescale is latched when a start edge is detected and held for the whole frame. Any value other than 8, 16 or 32 is treated as 8.
- Bit timing: edge_cnt runs 0..P-1 within each bit, and bit_cnt counts bits. The detection cycle (IDLE with RX_IN=0) is edge 0 of the start bit.
- Sampling: RX_IN is captured at edges P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, resolved at edge P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: stays while RX_IN=1. RX_IN=0 goes to START with edge_cnt=1 on the next cycle.
  - START: if the voted start bit is 1 (glitch), return to IDLE at edge P/2+1 with no strobes. Otherwise go to DATA at edge P-1.
  - DATA: the voted bit i is shifted into position i (LSB first). After DATA_WIDTH bits, at edge P-1, go to PARITY if PAR_EN=1, else STOP. PAR_EN and PAR_TYP are latched at start detection.
  - PARITY: expected bit is XOR of the data bits for even parity, or its inverse for odd. A mismatch sets an internal par_flag.
  - STOP: the voted stop bit 0 sets stp_flag. At edge P-1, go to IDLE.
- Frame length N = 1 + DATA_WIDTH + PAR_EN + 1 bits. With detection at cycle 0, the last stop edge is cycle N*P-1.
- Strobes appear in cycle N*P, for exactly one cycle:
  - data_valid=1 and P_DATA=received byte only if par_flag=0 and stp_flag=0.
  - Otherwise par_err=par_flag and stp_err=stp_flag (both may be 1), data_valid=0, and P_DATA keeps its old value.
- Back-to-back frames: at cycle N*P the FSM is in IDLE. RX_IN=0 in that cycle starts the next frame with no lost cycle, and the strobes for the previous frame are still emitted in that cycle.
- A line held low (break) gives stp_err for that frame. The next frame is then detected immediately if RX_IN is still 0.
- RX_IN changes outside the sampling window have no effect.

Test Plan:
- Reset and idle: RST=1 for 2 cycles, then RX_IN=1 for 100 cycles. Required: all outputs 0, P_DATA=0x00, no strobes.
- Nominal frame: Prescale=8, PAR_EN=0, byte 0xA5 sent LSB first with correct stop bit; start detected at cycle 0. Required: data_valid=1 only in cycle 80, P_DATA=0xA5, par_err=stp_err=0.
- Parity, both types:
  - Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0. Required: data_valid in cycle 176, P_DATA=0x3C.
  - Repeat with PAR_TYP=1 and parity bit 0. Required: par_err=1 for one cycle, data_valid=0, P_DATA still 0x3C.
- Stop error and glitch:
  - Prescale=32, byte 0x81, stop bit driven 0. Required: stp_err pulse in cycle 320, no data_valid.
  - Separately, RX_IN low for 3 cycles from IDLE. Required: return to IDLE, no strobes.
- Majority vote and back-to-back:
  - Prescale=8, bytes 0x55 then 0xF0 with zero idle gap, and one cycle of each sampling window inverted. Required: data_valid at cycles 80 and 160 with P_DATA=0x55 then 0xF0.
- Reset mid-frame and bad Prescale:
  - Assert RST at data bit 4 of a frame. Required: no strobes, next clean frame received correctly.
  - Prescale=12. Required: timing identical to the Prescale=8 case.
